somador_sequencial: RTL

SOMADOR_SEQUENCIAL -- requirements
Module: somador_sequencial

---
 rtl/somador_sequencial_if.sv | 30 +++
 rtl/somador_sequencial.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/somador_sequencial_if.sv
// Handshake and data bundle for the digit-serial adder/subtractor.
//   start, a, b, cin, sub, acc, clr : request side (driven by the master)
//   s, cout, ovf, busy, done        : result/status side (driven by the adder)
// WIDTH must match the WIDTH of the somador_sequencial instance it connects to.
interface somador_sequencial_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             acc;
  logic             clr;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, cin, sub, acc, clr,
    input  s, cout, ovf, busy, done
  );

  modport slave (
    input  start, a, b, cin, sub, acc, clr,
    output s, cout, ovf, busy, done
  );
endinterface

// File: rtl/somador_sequencial.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB slice first.
// Ports:
//   clk   : clock, rising edge active
//   rst_n : asynchronous active-low reset
//   bus   : somador_sequencial_if.slave
//           start - request an operation (sampled in IDLE only)
//           a, b  - operands (a ignored when acc=1, s used instead)
//           cin   - carry-in (borrow-in when sub=1)
//           sub   - 0 add, 1 subtract (a + ~b + ~cin)
//           acc   - take operand A from the current s register
//           clr   - clear s/cout/ovf, honoured in IDLE only
//           s     - registered result, held between completions
//           cout  - final carry-out (sub=1: 1 means no borrow)
//           ovf   - two's-complement overflow of the last operation
//           busy  - high in CALC and DONE
//           done  - one-cycle pulse in DONE
// Timing: start sampled at edge T; slices are added at edges T+1..T+N,
// the result is committed and DONE entered at edge T+N+1, IDLE again at T+N+2.
module somador_sequencial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  somador_sequencial_if.slave  bus
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $error("somador_sequencial: DIGIT must be in 1..WIDTH");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("somador_sequencial: WIDTH must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;      // operand A, shifted right one slice per step
  logic [WIDTH-1:0] b_r;      // operand B' (already inverted for subtract)
  logic             carry_r;  // carry between slices
  logic [WIDTH-1:0] part_r;   // partial sum, filled from the top down
  logic             ovf_r;    // overflow of the most recent slice
  logic [CW-1:0]    cnt;      // slices added so far
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             ovf_o;
  logic             busy_r;
  logic             done_r;

  logic [DIGIT:0]   slice;
  logic             msb_cin;

  // Current slice: low DIGIT bits of the shifting operands plus carry.
  // The carry into the slice MSB is recovered from its sum bit, which on the
  // final slice is the carry into the word MSB used for overflow.
  always_comb begin
    slice   = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
            + (DIGIT+1)'(carry_r);
    msb_cin = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice[DIGIT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      part_r  <= '0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
      s_r     <= '0;
      cout_r  <= 1'b0;
      ovf_o   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr) begin
            s_r    <= '0;
            cout_r <= 1'b0;
            ovf_o  <= 1'b0;
          end
          if (bus.start) begin
            // A clear in the same cycle wins over the accumulator feedback.
            if (bus.acc) a_r <= bus.clr ? '0 : s_r;
            else         a_r <= bus.a;
            b_r     <= bus.sub ? ~bus.b : bus.b;
            carry_r <= bus.cin ^ bus.sub;
            part_r  <= '0;
            ovf_r   <= 1'b0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= CALC;
          end
        end

        CALC: begin
          if (cnt == LAST) begin
            s_r    <= part_r;
            cout_r <= carry_r;
            ovf_o  <= ovf_r;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            carry_r <= slice[DIGIT];
            // After N steps the first slice has reached the bottom of part_r.
            part_r  <= (part_r >> DIGIT)
                     | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
            ovf_r   <= slice[DIGIT] ^ msb_cin;
            cnt     <= cnt + 1'b1;
          end
        end

        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.s    = s_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_o;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
